// File: rtl/qspi_mem_arbiter.sv
// Round-robin arbiter sharing one quad-SPI bus between an instruction read port and a data read/write port.
// Flash on ce0, PSRAM on ce1; each nibble takes two clk cycles; requests are sampled only in IDLE.
module qspi_mem_arbiter #(
  parameter int         DUMMY_CYCLES = 6,
  parameter logic [7:0] CMD_READ     = 8'hEB,
  parameter logic [7:0] CMD_WRITE    = 8'h38
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_valid,
  input  logic [24:0] i_addr,
  output logic        i_ready,
  output logic [31:0] i_rdata,
  input  logic        d_valid,
  input  logic        d_we,
  input  logic [24:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_ready,
  output logic [31:0] d_rdata,
  output logic        ce0,
  output logic        ce1,
  output logic        sclk,
  output logic [3:0]  sio_o,
  input  logic [3:0]  sio_i,
  output logic [3:0]  sio_oe
);

  typedef enum logic [2:0] {IDLE, CMD, ADDR, DUMMY, RDATA, WDATA, DONE} state_t;

  localparam logic [7:0] LP_DUMMY_LAST = 8'(DUMMY_CYCLES - 1);

  state_t      r_state;
  logic        r_phase;
  logic [7:0]  r_cnt;
  logic        r_sel_d;
  logic        r_we;
  logic [23:0] r_addr;
  logic [31:0] r_wdata;
  logic [31:0] r_shift;
  logic        r_last_d;
  logic        r_hold;
  logic        r_ce0, r_ce1, r_sclk;
  logic [3:0]  r_sio_o, r_sio_oe;
  logic        r_i_ready, r_d_ready;
  logic [31:0] r_i_rdata, r_d_rdata;

  logic        w_grant_d;
  logic [24:0] w_req_addr;
  logic        w_req_we;
  logic [2:0]  w_next_n;
  logic [4:0]  w_nib_idx;
  logic [3:0]  w_wr_nib;
  logic [3:0]  w_addr_nib;
  logic [31:0] w_rdata_full;

  assign ce0     = r_ce0;
  assign ce1     = r_ce1;
  assign sclk    = r_sclk;
  assign sio_o   = r_sio_o;
  assign sio_oe  = r_sio_oe;
  assign i_ready = r_i_ready;
  assign d_ready = r_d_ready;
  assign i_rdata = r_i_rdata;
  assign d_rdata = r_d_rdata;

  // Byte k sits at bits 8k+7:8k with its high nibble transferred first.
  always_comb begin
    w_grant_d    = d_valid && (!i_valid || !r_last_d);
    w_req_addr   = w_grant_d ? d_addr : i_addr;
    w_req_we     = w_grant_d && d_we;
    w_next_n     = r_cnt[2:0] + 3'd1;
    w_nib_idx    = {r_cnt[2:1], ~r_cnt[0], 2'b00};
    w_wr_nib     = r_wdata[{w_next_n[2:1], ~w_next_n[0], 2'b00} +: 4];
    w_rdata_full = {r_shift[31:28], sio_i, r_shift[23:0]};
    case (w_next_n)
      3'd1:    w_addr_nib = r_addr[19:16];
      3'd2:    w_addr_nib = r_addr[15:12];
      3'd3:    w_addr_nib = r_addr[11:8];
      3'd4:    w_addr_nib = r_addr[7:4];
      3'd5:    w_addr_nib = r_addr[3:0];
      default: w_addr_nib = r_addr[23:20];
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_phase   <= 1'b0;
      r_cnt     <= '0;
      r_sel_d   <= 1'b0;
      r_we      <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_shift   <= '0;
      r_last_d  <= 1'b1;
      r_hold    <= 1'b0;
      r_ce0     <= 1'b1;
      r_ce1     <= 1'b1;
      r_sclk    <= 1'b0;
      r_sio_o   <= '0;
      r_sio_oe  <= '0;
      r_i_ready <= 1'b0;
      r_d_ready <= 1'b0;
      r_i_rdata <= '0;
      r_d_rdata <= '0;
    end else begin
      r_i_ready <= 1'b0;
      r_d_ready <= 1'b0;
      case (r_state)
        IDLE: begin
          r_hold <= 1'b0;
          if (!r_hold && (i_valid || d_valid)) begin
            r_sel_d  <= w_grant_d;
            r_last_d <= w_grant_d;
            r_we     <= w_req_we;
            r_addr   <= w_req_addr[23:0];
            r_wdata  <= d_wdata;
            r_phase  <= 1'b0;
            r_cnt    <= '0;
            // Flash is read-only: writes to it complete without touching the bus.
            if (w_req_we && !w_req_addr[24]) begin
              r_state   <= DONE;
              r_d_ready <= 1'b1;
            end else begin
              r_state  <= CMD;
              r_ce0    <= w_req_addr[24];
              r_ce1    <= !w_req_addr[24];
              r_sclk   <= 1'b0;
              r_sio_o  <= w_req_we ? CMD_WRITE[7:4] : CMD_READ[7:4];
              r_sio_oe <= 4'hF;
            end
          end
        end
        DONE: begin
          r_state <= IDLE;
          r_hold  <= 1'b1;
        end
        default: begin
          if (!r_phase) begin
            r_phase <= 1'b1;
            r_sclk  <= 1'b1;
          end else begin
            r_phase <= 1'b0;
            r_sclk  <= 1'b0;
            case (r_state)
              CMD: begin
                if (r_cnt == 8'd0) begin
                  r_cnt   <= 8'd1;
                  r_sio_o <= r_we ? CMD_WRITE[3:0] : CMD_READ[3:0];
                end else begin
                  r_cnt   <= '0;
                  r_state <= ADDR;
                  r_sio_o <= r_addr[23:20];
                end
              end
              ADDR: begin
                if (r_cnt == 8'd5) begin
                  r_cnt <= '0;
                  if (r_we) begin
                    r_state <= WDATA;
                    r_sio_o <= r_wdata[7:4];
                  end else begin
                    r_state  <= (DUMMY_CYCLES == 0) ? RDATA : DUMMY;
                    r_sio_o  <= '0;
                    r_sio_oe <= '0;
                  end
                end else begin
                  r_cnt   <= r_cnt + 8'd1;
                  r_sio_o <= w_addr_nib;
                end
              end
              DUMMY: begin
                if (r_cnt == LP_DUMMY_LAST) begin
                  r_cnt   <= '0;
                  r_state <= RDATA;
                end else begin
                  r_cnt <= r_cnt + 8'd1;
                end
              end
              RDATA: begin
                r_shift[w_nib_idx +: 4] <= sio_i;
                if (r_cnt == 8'd7) begin
                  r_state   <= DONE;
                  r_ce0     <= 1'b1;
                  r_ce1     <= 1'b1;
                  r_i_ready <= !r_sel_d;
                  r_d_ready <= r_sel_d;
                  if (r_sel_d) r_d_rdata <= w_rdata_full;
                  else         r_i_rdata <= w_rdata_full;
                end else begin
                  r_cnt <= r_cnt + 8'd1;
                end
              end
              WDATA: begin
                if (r_cnt == 8'd7) begin
                  r_state   <= DONE;
                  r_ce0     <= 1'b1;
                  r_ce1     <= 1'b1;
                  r_sio_o   <= '0;
                  r_sio_oe  <= '0;
                  r_d_ready <= 1'b1;
                end else begin
                  r_cnt   <= r_cnt + 8'd1;
                  r_sio_o <= w_wr_nib;
                end
              end
              default: r_state <= IDLE;
            endcase
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_qspi_mem_arbiter.sv
// Bench for qspi_mem_arbiter: a pin-level flash/PSRAM model plus per-port scoreboards of expected read data.
module tb_qspi_mem_arbiter;

  localparam int D = 6;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_valid, d_valid, d_we;
  logic [24:0] i_addr, d_addr;
  logic [31:0] d_wdata;
  logic        i_ready, d_ready, ce0, ce1, sclk;
  logic [31:0] i_rdata, d_rdata;
  logic [3:0]  sio_o, sio_i, sio_oe;

  logic        i_valid8, i_ready8, d_ready8, ce0_8, ce1_8, sclk8;
  logic [24:0] i_addr8;
  logic [31:0] i_rdata8, d_rdata8;
  logic [3:0]  sio_o8, sio_oe8;

  always #5 clk = ~clk;

  qspi_mem_arbiter dut (
    .clk(clk), .rst(rst),
    .i_valid(i_valid), .i_addr(i_addr), .i_ready(i_ready), .i_rdata(i_rdata),
    .d_valid(d_valid), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ready(d_ready), .d_rdata(d_rdata),
    .ce0(ce0), .ce1(ce1), .sclk(sclk), .sio_o(sio_o), .sio_i(sio_i), .sio_oe(sio_oe)
  );

  qspi_mem_arbiter #(.DUMMY_CYCLES(8)) dut8 (
    .clk(clk), .rst(rst),
    .i_valid(i_valid8), .i_addr(i_addr8), .i_ready(i_ready8), .i_rdata(i_rdata8),
    .d_valid(1'b0), .d_we(1'b0), .d_addr(25'h0), .d_wdata(32'h0),
    .d_ready(d_ready8), .d_rdata(d_rdata8),
    .ce0(ce0_8), .ce1(ce1_8), .sclk(sclk8), .sio_o(sio_o8), .sio_i(4'hA), .sio_oe(sio_oe8)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  // ---------------- pin-level device model ----------------
  logic [7:0] psram [int];
  logic [7:0] ref_mem [int];
  logic [3:0] nib [0:31];
  int cnt = 0;
  int ce0_low = 0, ce1_low = 0, sclk_hi = 0;

  function automatic logic [7:0] flash_byte(input logic [23:0] a);
    case (a)
      24'h000100: return 8'h11;
      24'h000101: return 8'h22;
      24'h000102: return 8'h33;
      24'h000103: return 8'h44;
      default:    return a[7:0] ^ 8'h5A;
    endcase
  endfunction

  function automatic logic [23:0] bus_addr();
    return {nib[2], nib[3], nib[4], nib[5], nib[6], nib[7]};
  endfunction

  always @(negedge clk) begin
    int j, key;
    logic [7:0] b;
    if (!ce0) ce0_low++;
    if (!ce1) ce1_low++;
    if (sclk) sclk_hi++;
    if (ce0 && ce1) begin
      cnt   = 0;
      sio_i = 4'h0;
    end else if (sclk) begin
      if (cnt < 32) nib[cnt] = sio_o;
      if (cnt >= 8 && cnt < 16 && !ce1 && {nib[0], nib[1]} == 8'h38) begin
        j   = cnt - 8;
        key = int'(bus_addr()) + j / 2;
        b   = psram.exists(key) ? psram[key] : 8'h00;
        if (j % 2 == 0) b[7:4] = sio_o;
        else            b[3:0] = sio_o;
        psram[key] = b;
      end
      cnt++;
    end else begin
      sio_i = 4'h0;
      if (cnt >= 8 + D && cnt < 16 + D) begin
        j   = cnt - 8 - D;
        key = int'(bus_addr()) + j / 2;
        if (!ce0) b = flash_byte(24'(key));
        else      b = psram.exists(key) ? psram[key] : 8'h00;
        sio_i = (j % 2 == 0) ? b[7:4] : b[3:0];
      end
    end
  end

  // ---------------- scoreboard ----------------
  logic [31:0] exp_i_q[$];
  logic [31:0] exp_d_q[$];
  logic [31:0] last_d_exp = 32'h0;

  function automatic logic [31:0] exp_word(input logic [24:0] a);
    logic [31:0] w;
    int key;
    for (int k = 0; k < 4; k++) begin
      key = int'(a[23:0]) + k;
      if (a[24]) w[8*k +: 8] = ref_mem.exists(key) ? ref_mem[key] : 8'h00;
      else       w[8*k +: 8] = flash_byte(24'(key));
    end
    return w;
  endfunction

  always @(negedge clk) begin
    if (!rst) begin
      if (i_ready) begin
        check("d_ready_while_i", 32'(d_ready), 32'h0);
        if (exp_i_q.size() == 0) check("i_ready_unexpected", 32'(i_ready), 32'h0);
        else                     check("i_rdata", i_rdata, exp_i_q.pop_front());
      end
      if (d_ready) begin
        if (exp_d_q.size() == 0) check("d_ready_unexpected", 32'(d_ready), 32'h0);
        else                     check("d_rdata", d_rdata, exp_d_q.pop_front());
      end
    end
  end

  // Called at a negedge; returns cycles from valid assertion to ready (-1 on timeout).
  task automatic req(input bit dport, input bit we, input logic [24:0] a,
                     input logic [31:0] wd, output int lat);
    int t0;
    if (!dport) begin
      exp_i_q.push_back(exp_word(a));
      i_addr  = a;
      i_valid = 1'b1;
    end else begin
      if (we) begin
        if (a[24]) for (int k = 0; k < 4; k++) ref_mem[int'(a[23:0]) + k] = wd[8*k +: 8];
      end else begin
        last_d_exp = exp_word(a);
      end
      exp_d_q.push_back(last_d_exp);
      d_we    = we;
      d_addr  = a;
      d_wdata = wd;
      d_valid = 1'b1;
    end
    t0  = cyc;
    lat = -1;
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      if (dport ? d_ready : i_ready) begin
        lat = cyc - t0;
        break;
      end
    end
    if (!dport) i_valid = 1'b0;
    else        d_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int lat, lat_i1, lat_i2, lat_d, c0, c1, sh, t0, bad_oe;
    rst = 1'b1; i_valid = 1'b0; d_valid = 1'b0; d_we = 1'b0;
    i_addr = '0; d_addr = '0; d_wdata = '0; sio_i = 4'h0;
    i_valid8 = 1'b0; i_addr8 = '0;
    idle(3);
    check("rst_ce", 32'({ce0, ce1, ce0_8, ce1_8}), 32'hF);
    check("rst_sclk_oe_o", 32'({sclk, sio_oe, sio_o}), 32'h0);
    check("rst_ready", 32'({i_ready, d_ready}), 32'h0);
    check("rst_i_rdata", i_rdata, 32'h0);
    check("rst_d_rdata", d_rdata, 32'h0);
    rst = 1'b0;
    idle(2);

    // flash read
    c1 = ce1_low;
    req(0, 0, 25'h0000100, 32'h0, lat);
    check("flash_rd_lat", 32'(lat), 32'd45);
    check("flash_rd_cmd", 32'({nib[0], nib[1]}), 32'hEB);
    check("flash_rd_addr", 32'(bus_addr()), 32'h000100);
    check("flash_rd_data", i_rdata, 32'h44332211);
    check("flash_rd_ce1_idle", 32'(ce1_low - c1), 32'h0);
    idle(3);

    // PSRAM write then read back
    c0 = ce0_low;
    req(1, 1, 25'h1000010, 32'hDEADBEEF, lat);
    check("ps_wr_lat", 32'(lat), 32'd33);
    check("ps_wr_cmd", 32'({nib[0], nib[1]}), 32'h38);
    check("ps_wr_addr", 32'(bus_addr()), 32'h000010);
    check("ps_wr_nibs", {nib[8], nib[9], nib[10], nib[11], nib[12], nib[13], nib[14], nib[15]}, 32'hEFBEADDE);
    idle(3);
    req(1, 0, 25'h1000010, 32'h0, lat);
    check("ps_rd_lat", 32'(lat), 32'd45);
    check("ps_rd_data", d_rdata, 32'hDEADBEEF);
    check("ps_ce0_idle", 32'(ce0_low - c0), 32'h0);
    idle(3);

    // instruction read, then flash write must move the pointer to the data port
    req(0, 0, 25'h0000040, 32'h0, lat);
    check("i_rd2_lat", 32'(lat), 32'd45);
    idle(3);
    c0 = ce0_low; c1 = ce1_low; sh = sclk_hi;
    req(1, 1, 25'h0000004, 32'h12345678, lat);
    check("flash_wr_lat", 32'(lat), 32'd1);
    check("flash_wr_bus_quiet", 32'((ce0_low - c0) + (ce1_low - c1) + (sclk_hi - sh)), 32'h0);
    check("flash_wr_rdata_held", d_rdata, 32'hDEADBEEF);
    idle(3);

    // contention: instruction first, then data wins against an immediate instruction re-request
    fork
      begin
        req(0, 0, 25'h0000200, 32'h0, lat_i1);
        req(0, 0, 25'h1000010, 32'h0, lat_i2);
      end
      req(1, 0, 25'h1000012, 32'h0, lat_d);
    join
    check("cont_i1_lat", 32'(lat_i1), 32'd45);
    check("cont_d_lat", 32'(lat_d), 32'd92);
    check("cont_i2_lat", 32'(lat_i2), 32'd94);
    idle(3);

    // reset 20 cycles into a read aborts it
    i_addr = 25'h0000300; i_valid = 1'b1;
    idle(20);
    rst = 1'b1; i_valid = 1'b0;
    idle(1);
    check("abort_ce0", 32'(ce0), 32'h1);
    check("abort_oe", 32'(sio_oe), 32'h0);
    check("abort_ready", 32'({i_ready, d_ready}), 32'h0);
    rst = 1'b0;
    last_d_exp = 32'h0;
    idle(3);
    req(0, 0, 25'h0000100, 32'h0, lat);
    check("post_abort_lat", 32'(lat), 32'd45);
    check("post_abort_data", i_rdata, 32'h44332211);
    idle(3);

    // DUMMY_CYCLES = 8 instance
    i_addr8 = 25'h0000100; i_valid8 = 1'b1;
    t0 = cyc; lat = -1; bad_oe = 0;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (i_ready8) begin
        lat = cyc - t0;
        break;
      end
      if (cyc - t0 >= 17 && sio_oe8 != 4'h0) bad_oe++;
    end
    i_valid8 = 1'b0;
    check("d8_lat", 32'(lat), 32'd49);
    check("d8_oe_quiet", 32'(bad_oe), 32'h0);
    check("d8_rdata", i_rdata8, 32'hAAAAAAAA);
    idle(3);

    check("sb_i_empty", 32'(exp_i_q.size()), 32'h0);
    check("sb_d_empty", 32'(exp_d_q.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
